// File: rtl/hex_display_arbiter_if.sv
// Display request/value bundle between the requesters (CPU PIO, game logic)
// and the hex display arbiter, plus the scanned segment pins.
interface hex_display_arbiter_if;
    // game_req is a level request held for as long as the game wants the display;
    // game_grant answers it one clock later and drops one clock after the request
    // falls, while src_sel keeps pointing at the frozen game value until the hold expires.
    logic [15:0] pio_value;
    logic        game_req;
    logic [15:0] game_value;
    logic        blank_lz;
    logic        game_grant;
    logic        src_sel;
    logic [3:0]  hex_an;
    logic [6:0]  hex_seg;

    modport master (
        output pio_value, game_req, game_value, blank_lz,
        input  game_grant, src_sel, hex_an, hex_seg
    );

    modport slave (
        input  pio_value, game_req, game_value, blank_lz,
        output game_grant, src_sel, hex_an, hex_seg
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Two-source arbiter for a 4-digit seven-segment display: PIO/game ownership with a
// post-release hold, tear-free frame latching, digit scanning and hex decode.
module hex_display_arbiter #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    hex_display_arbiter_if.slave bus_if,
    output logic [1:0]           dbg_state_o
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PIO  = 2'd0,
        S_GAME = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [15:0]     disp_val_q;
    logic            game_grant_q;
    logic            src_sel_q;

    logic [PW-1:0]   presc_q;
    logic [1:0]      digit_q;
    logic [15:0]     frame_val_q;

    logic [3:0]      hex_an_q;
    logic [6:0]      hex_seg_q;
    logic [3:0]      hex_an_d;
    logic [6:0]      hex_seg_d;
    logic [3:0]      nibble;
    logic [15:0]     upper_val;
    logic [6:0]      code;

    // Ownership FSM; grant and source select are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_PIO;
            hold_cnt_q   <= '0;
            disp_val_q   <= '0;
            game_grant_q <= 1'b0;
            src_sel_q    <= 1'b0;
        end else begin
            case (state_q)
                S_PIO: begin
                    disp_val_q <= bus_if.pio_value;
                    if (bus_if.game_req) begin
                        state_q      <= S_GAME;
                        game_grant_q <= 1'b1;
                        src_sel_q    <= 1'b1;
                    end
                end
                S_GAME: begin
                    if (bus_if.game_req) begin
                        disp_val_q <= bus_if.game_value;
                    end else begin
                        state_q      <= S_HOLD;
                        hold_cnt_q   <= HOLD_LOAD;
                        game_grant_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // A fresh request wins even on the cycle the hold would expire.
                    if (bus_if.game_req) begin
                        state_q      <= S_GAME;
                        game_grant_q <= 1'b1;
                    end else if (hold_cnt_q == '0) begin
                        state_q   <= S_PIO;
                        src_sel_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HW'(1);
                    end
                end
                default: begin
                    state_q      <= S_PIO;
                    game_grant_q <= 1'b0;
                    src_sel_q    <= 1'b0;
                end
            endcase
        end
    end

    // Scanner: the frame only reloads as digit 3 finishes, so a frame never mixes values.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            digit_q     <= 2'd0;
            frame_val_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            digit_q <= digit_q + 2'd1;
            if (digit_q == 2'd3) begin
                frame_val_q <= disp_val_q;
            end
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    always_comb begin
        upper_val = frame_val_q >> {digit_q, 2'b00};
        nibble    = upper_val[3:0];
        case (nibble)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        // upper_val holds this digit and everything above it; zero means a leading zero.
        if (bus_if.blank_lz && (digit_q != 2'd0) && (upper_val == 16'h0000)) begin
            hex_seg_d = 7'h7F;
        end else begin
            hex_seg_d = code;
        end
        hex_an_d = ~(4'b0001 << digit_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_an_q  <= 4'hF;
            hex_seg_q <= 7'h7F;
        end else begin
            hex_an_q  <= hex_an_d;
            hex_seg_q <= hex_seg_d;
        end
    end

    assign bus_if.game_grant = game_grant_q;
    assign bus_if.src_sel    = src_sel_q;
    assign bus_if.hex_an     = hex_an_q;
    assign bus_if.hex_seg    = hex_seg_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: decode table vectors, directed ownership/reset
// sequences, and a randomized run against a deadline-based reference model.
module tb_hex_display_arbiter;

    localparam int SD = 4;
    localparam int HC = 8;
    localparam int FR = 4 * SD;
    localparam logic [1:0] ST_PIO  = 2'd0;
    localparam logic [1:0] ST_GAME = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam int M_PIO = 0, M_GAME = 1, M_HOLD = 2;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc;
    int         checks;
    int         errors;

    hex_display_arbiter_if dif ();

    hex_display_arbiter #(
        .SCAN_DIV    (SD),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_if      (dif),
        .dbg_state_o (dbg_state)
    );

    // ---- clock / reset ----
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---- driver tasks and helpers ----
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] f, input int d, input logic blk);
        logic [15:0] upper;
        upper = f >> (4 * d);
        if (d != 0 && blk && upper == 16'h0) return 7'h7F;
        return seg_of(upper[3:0]);
    endfunction

    function automatic logic [27:0] frame_segs(input logic [15:0] f, input logic blk);
        return {exp_seg(f, 3, blk), exp_seg(f, 2, blk), exp_seg(f, 1, blk), exp_seg(f, 0, blk)};
    endfunction

    // Advance until a frame boundary that is guaranteed to latch the current inputs.
    task automatic align();
        tick();
        tick();
        while (cyc % FR != 0) tick();
    endtask

    // Scoreboard: queue the 16 expected (anode, segment) pins of one frame, then pop per cycle.
    task automatic check_frame(input logic [27:0] segs, input string nm);
        logic [10:0] exp_q[$];
        logic [10:0] e;
        logic [3:0]  an_e;
        for (int i = 0; i < FR; i++) begin
            an_e = ~(4'b0001 << (i / SD));
            exp_q.push_back({an_e, segs[7 * (i / SD) +: 7]});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            chk({nm, "_an"}, 32'(dif.hex_an), 32'(e[10:7]));
            chk({nm, "_seg"}, 32'(dif.hex_seg), 32'(e[6:0]));
        end
    endtask

    task automatic check_reset_pins(input string nm);
        chk({nm, "_grant"}, 32'(dif.game_grant), 32'h0);
        chk({nm, "_src"}, 32'(dif.src_sel), 32'h0);
        chk({nm, "_an"}, 32'(dif.hex_an), 32'hF);
        chk({nm, "_seg"}, 32'(dif.hex_seg), 32'h7F);
        chk({nm, "_state"}, 32'(dbg_state), 32'(ST_PIO));
    endtask

    // ---- reference model: ownership by absolute deadline, frames from a value history ----
    logic [15:0] disp_hist[0:1023];
    int          m_owner;
    int          m_expire;

    task automatic model_step(input int t, input logic req, input logic [15:0] gv,
                              input logic [15:0] pv);
        logic [15:0] dv;
        dv = disp_hist[t - 1];
        if (m_owner == M_PIO) begin
            dv = pv;
            if (req) m_owner = M_GAME;
        end else if (m_owner == M_GAME) begin
            if (req) dv = gv;
            else begin
                m_owner  = M_HOLD;
                m_expire = t + HC;
            end
        end else begin
            if (req) m_owner = M_GAME;
            else if (t >= m_expire) m_owner = M_PIO;
        end
        disp_hist[t] = dv;
    endtask

    typedef struct {
        logic [15:0] pio;
        logic        blank;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs[10];

    // ---- stimulus ----
    initial begin
        int          run_left;
        int          t, d, k;
        logic [15:0] fv;
        logic [3:0]  an_e;

        vecs[0] = '{16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h0030, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}};
        vecs[2] = '{16'h0030, 1'b0, {7'h40, 7'h40, 7'h30, 7'h40}};
        vecs[3] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{16'h0100, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}};
        vecs[5] = '{16'hF000, 1'b1, {7'h0E, 7'h40, 7'h40, 7'h40}};
        vecs[6] = '{16'h8421, 1'b1, {7'h00, 7'h19, 7'h24, 7'h79}};
        vecs[7] = '{16'hBCDE, 1'b0, {7'h03, 7'h46, 7'h21, 7'h06}};
        vecs[8] = '{16'h5670, 1'b0, {7'h12, 7'h02, 7'h78, 7'h40}};
        vecs[9] = '{16'h0009, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h10}};

        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        dif.pio_value  = 16'h12AF;
        dif.game_req   = 1'b0;
        dif.game_value = 16'h0000;
        dif.blank_lz   = 1'b0;

        tick();
        tick();
        check_reset_pins("reset");
        reset = 1'b0;
        cyc   = 0;

        check_frame(frame_segs(16'h0000, 1'b0), "first_frame");
        check_frame(vecs[0].segs, "frame_12af_a");
        check_frame(vecs[0].segs, "frame_12af_b");

        for (int i = 0; i < 10; i++) begin
            dif.pio_value = vecs[i].pio;
            dif.blank_lz  = vecs[i].blank;
            align();
            check_frame(vecs[i].segs, $sformatf("vec%0d", i));
        end

        // Grant, hold and release
        dif.pio_value  = 16'h12AF;
        dif.blank_lz   = 1'b0;
        dif.game_value = 16'h9999;
        dif.game_req   = 1'b1;
        tick();
        chk("grant_rise", 32'(dif.game_grant), 32'h1);
        chk("src_rise", 32'(dif.src_sel), 32'h1);
        align();
        check_frame(frame_segs(16'h9999, 1'b0), "game_frame");
        dif.game_req = 1'b0;
        tick();
        chk("grant_fall", 32'(dif.game_grant), 32'h0);
        chk("src_in_hold", 32'(dif.src_sel), 32'h1);
        for (int i = 1; i < HC; i++) begin
            tick();
            chk($sformatf("src_hold%0d", i), 32'(dif.src_sel), 32'h1);
        end
        tick();
        chk("src_release", 32'(dif.src_sel), 32'h0);
        chk("state_release", 32'(dbg_state), 32'(ST_PIO));
        align();
        check_frame(vecs[0].segs, "pio_back");

        // Re-grant on the very cycle the hold would expire
        dif.game_req = 1'b1;
        tick();
        dif.game_req = 1'b0;
        tick();
        for (int i = 1; i < HC; i++) tick();
        chk("hold_at_zero", 32'(dbg_state), 32'(ST_HOLD));
        dif.game_req = 1'b1;
        tick();
        chk("regrant_state", 32'(dbg_state), 32'(ST_GAME));
        chk("regrant_src", 32'(dif.src_sel), 32'h1);
        chk("regrant_grant", 32'(dif.game_grant), 32'h1);
        tick();

        // Reset in the middle of a hold
        dif.game_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        check_reset_pins("midhold_reset");
        reset = 1'b0;
        cyc   = 0;
        check_frame(frame_segs(16'h0000, 1'b0), "post_reset_frame");

        // Randomized run against the model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
        disp_hist[0] = 16'h0000;
        m_owner  = M_PIO;
        m_expire = 0;
        run_left = 0;
        for (int n = 0; n < 40 * FR; n++) begin
            dif.pio_value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dif.game_value = 16'($urandom);
            if (run_left == 0) begin
                dif.game_req = ($urandom_range(0, 2) == 0);
                run_left     = $urandom_range(1, 24);
            end
            run_left--;
            if ($urandom_range(0, 19) == 0) dif.blank_lz = ~dif.blank_lz;
            tick();
            t = cyc;
            model_step(t, dif.game_req, dif.game_value, dif.pio_value);
            d  = ((t - 1) / SD) % 4;
            k  = (t - 1) / FR;
            fv = (k == 0) ? 16'h0000 : disp_hist[FR * k - 1];
            an_e = ~(4'b0001 << d);
            chk("rnd_an", 32'(dif.hex_an), 32'(an_e));
            chk("rnd_seg", 32'(dif.hex_seg), 32'(exp_seg(fv, d, dif.blank_lz)));
            chk("rnd_grant", 32'(dif.game_grant), 32'(m_owner == M_GAME));
            chk("rnd_src", 32'(dif.src_sel), 32'(m_owner != M_PIO));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
